// File: rtl/gf180mcu_as_ex_mcu7t5v0__trans_arb.sv
// Round-robin arbiter for a shared transmission-gate bus, with break-before-make
// dead time between owners and optional hold-time preemption.
module gf180mcu_as_ex_mcu7t5v0__trans_arb #(
  parameter int NREQ        = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] EN,
  output logic [NREQ-1:0] ENB,
  output logic            BUSY
);

  localparam int IW = $clog2(NREQ);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BBM  = 2'd1,
    ON   = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   ptr_r, ptr_nxt_s;
  logic [IW-1:0]   win_r, win_nxt_s;
  logic [DW-1:0]   dead_r, dead_nxt_s;
  logic [HW-1:0]   hold_r, hold_nxt_s, hold_inc_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [NREQ-1:0] enb_r;
  logic            busy_r;
  logic [NREQ-1:0] win_oh_s;
  logic            preempt_s;

  // First requester at or after ptr, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[IW-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win_oh_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_r;
  assign hold_inc_s = (hold_r == HOLD_MAX) ? hold_r : hold_r + 1'b1;
  // Preempt once the owner has completed MAX_HOLD ON cycles and someone else waits.
  assign preempt_s  = (HOLD_MAX != {HW{1'b0}}) && (hold_inc_s == HOLD_MAX) &&
                      (|(REQ & ~win_oh_s));

  // Next-state and next-output logic for the IDLE/BBM/ON sequence.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    win_nxt_s   = win_r;
    dead_nxt_s  = dead_r;
    hold_nxt_s  = hold_r;
    gnt_nxt_s   = gnt_r;
    case (state_r)
      IDLE: begin
        gnt_nxt_s = {NREQ{1'b0}};
        if (|REQ) begin
          win_nxt_s   = rr_pick(REQ, ptr_r);
          dead_nxt_s  = DEAD_LOAD;
          state_nxt_s = BBM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BBM: begin
        if (!REQ[win_r]) begin
          state_nxt_s = IDLE;
          dead_nxt_s  = {DW{1'b0}};
        end else if (dead_r == {DW{1'b0}}) begin
          state_nxt_s = ON;
          gnt_nxt_s   = win_oh_s;
          hold_nxt_s  = {HW{1'b0}};
        end else begin
          dead_nxt_s  = dead_r - 1'b1;
        end
      end
      ON: begin
        if (!REQ[win_r] || preempt_s) begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = {NREQ{1'b0}};
          hold_nxt_s  = {HW{1'b0}};
          ptr_nxt_s   = (win_r == LAST_IDX) ? {IW{1'b0}} : win_r + 1'b1;
        end else begin
          hold_nxt_s  = hold_inc_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {NREQ{1'b0}};
        dead_nxt_s  = {DW{1'b0}};
        hold_nxt_s  = {HW{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset opens every gate without waiting for CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      ptr_r   <= {IW{1'b0}};
      win_r   <= {IW{1'b0}};
      dead_r  <= {DW{1'b0}};
      hold_r  <= {HW{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      enb_r   <= {NREQ{1'b1}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      win_r   <= win_nxt_s;
      dead_r  <= dead_nxt_s;
      hold_r  <= hold_nxt_s;
      gnt_r   <= gnt_nxt_s;
      enb_r   <= ~gnt_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  assign GNT  = gnt_r;
  assign EN   = gnt_r;
  assign ENB  = enb_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_gf180mcu_as_ex_mcu7t5v0__trans_arb.sv
// Self-checking bench for the transmission-gate arbiter against a cycle-level
// behavioural model of ownership, dead time and preemption.
module tb_gf180mcu_as_ex_mcu7t5v0__trans_arb;

  localparam int N = 4;
  localparam int D = 2;
  localparam int H = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] REQ;
  logic [N-1:0] GNT, EN, ENB;
  logic         BUSY;

  int vectors     = 0;
  int miscompares = 0;

  // model: 0 idle, 1 dead time, 2 owner connected
  int           m_state, m_owner, m_ptr, m_bbm, m_on;
  logic [N-1:0] exp_gnt;
  logic         exp_busy;

  always #5 CLK = ~CLK;

  gf180mcu_as_ex_mcu7t5v0__trans_arb #(
    .NREQ(N), .DEAD_CYCLES(D), .MAX_HOLD(H)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .EN(EN), .ENB(ENB), .BUSY(BUSY)
  );

  // gate invariants checked on every falling edge of every scenario
  always @(negedge CLK) begin
    vectors++;
    if (ENB !== ~EN || !$onehot0(EN)) begin
      miscompares++;
      $display("FAIL gate_invariant: EN=%b ENB=%b, required ENB=~EN and EN one-hot-or-zero", EN, ENB);
    end
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] sh;
    for (int i = 0; i < N; i++) begin
      sh = r >> ((p + i) % N);
      if (sh[0]) return (p + i) % N;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_ptr = 0; m_bbm = 0; m_on = 0;
    exp_gnt = '0; exp_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] sh;
    logic [N-1:0] others;
    sh     = r >> m_owner;
    others = r & ~(4'b0001 << m_owner);
    case (m_state)
      0: if (r != 4'b0000) begin m_owner = pick(r, m_ptr); m_bbm = 0; m_state = 1; end
      1: if (!sh[0]) m_state = 0;
         else begin
           m_bbm++;
           if (m_bbm == D) begin m_state = 2; m_on = 0; end
         end
      2: begin
        m_on++;
        if (!sh[0] || (H > 0 && m_on >= H && others != 4'b0000)) begin
          m_state = 0;
          m_ptr   = (m_owner + 1) % N;
        end
      end
      default: m_state = 0;
    endcase
    exp_gnt  = (m_state == 2) ? (4'b0001 << m_owner) : 4'b0000;
    exp_busy = (m_state != 0);
  endtask

  task automatic tick(input logic [N-1:0] r);
    REQ = r;
    @(posedge CLK);
    model_edge(r);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    REQ = 4'b0000;
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    REQ = 4'b1111;
    RST = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (GNT !== 4'b0000 || EN !== 4'b0000 || ENB !== 4'b1111 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: GNT=%b EN=%b ENB=%b BUSY=%b, required 0000/0000/1111/0", GNT, EN, ENB, BUSY);
      end
    end
    REQ = 4'b0000;
    RST = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] req_tab [6]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [N-1:0] gnt_tab [6]  = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic         busy_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      tick(req_tab[i]);
      vectors++;
      if (GNT !== gnt_tab[i] || EN !== gnt_tab[i] || ENB !== ~gnt_tab[i] || BUSY !== busy_tab[i]) begin
        miscompares++;
        $display("FAIL single[%0d]: GNT=%b ENB=%b BUSY=%b, required GNT=%b ENB=%b BUSY=%b",
                 i, GNT, ENB, BUSY, gnt_tab[i], ~gnt_tab[i], busy_tab[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int           order [$];
    int           exp_order [5] = '{0, 1, 2, 3, 0};
    int           zero_run;
    logic [N-1:0] r, prev;
    do_reset();
    r = 4'b1111; prev = 4'b0000; zero_run = 0;
    for (int c = 0; c < 100 && order.size() < 5; c++) begin
      tick(r);
      vectors++;
      if (GNT !== exp_gnt || BUSY !== exp_busy) begin
        miscompares++;
        $display("FAIL rr_model: GNT=%b BUSY=%b, required GNT=%b BUSY=%b", GNT, BUSY, exp_gnt, exp_busy);
      end
      if (GNT != 4'b0000 && prev == 4'b0000) begin
        order.push_back($clog2(GNT));
        if (order.size() > 1) begin
          vectors++;
          if (zero_run < 3) begin
            miscompares++;
            $display("FAIL rr_gap: %0d zero-EN cycles, required at least 3", zero_run);
          end
        end
        zero_run = 0;
      end else if (EN == 4'b0000) zero_run++;
      prev = GNT;
      r = (exp_gnt != 4'b0000) ? (4'b1111 & ~exp_gnt) : 4'b1111;
    end
    vectors++;
    if (order.size() != 5) begin
      miscompares++;
      $display("FAIL rr_count: %0d grants seen, required 5", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      vectors++;
      if (order[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: owner %0d, required %0d", i, order[i], exp_order[i]);
      end
    end
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_preempt();
    int owner0 = 0, gap = 0;
    bit got2 = 0;
    for (int c = 0; c < 10 && GNT != 4'b0001; c++) tick(4'b0001);
    for (int c = 0; c < 40 && !got2; c++) begin
      if (GNT == 4'b0001) owner0++;
      else if (GNT == 4'b0000) gap++;
      tick(4'b0101);
      vectors++;
      if (GNT !== exp_gnt || BUSY !== exp_busy) begin
        miscompares++;
        $display("FAIL preempt_model: GNT=%b BUSY=%b, required GNT=%b BUSY=%b", GNT, BUSY, exp_gnt, exp_busy);
      end
      if (GNT == 4'b0100) got2 = 1;
    end
    vectors++;
    if (owner0 != 16 || gap != 3 || !got2) begin
      miscompares++;
      $display("FAIL preempt_timing: owner0 cycles=%0d gap=%0d reached_2=%0d, required 16/3/1", owner0, gap, got2);
    end
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_abort();
    logic [N-1:0] req_tab [7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
    logic [N-1:0] gnt_tab [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic         bsy_tab [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(req_tab[i]);
      vectors++;
      if (GNT !== gnt_tab[i] || BUSY !== bsy_tab[i]) begin
        miscompares++;
        $display("FAIL abort[%0d]: GNT=%b BUSY=%b, required GNT=%b BUSY=%b", i, GNT, BUSY, gnt_tab[i], bsy_tab[i]);
      end
    end
    tick(4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      tick(r);
      vectors++;
      if (GNT !== exp_gnt || EN !== exp_gnt || ENB !== ~exp_gnt || BUSY !== exp_busy) begin
        miscompares++;
        $display("FAIL random[%0d]: REQ=%b GNT=%b ENB=%b BUSY=%b, required GNT=%b ENB=%b BUSY=%b",
                 c, r, GNT, ENB, BUSY, exp_gnt, ~exp_gnt, exp_busy);
      end
    end
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 10 && GNT != 4'b0001; c++) tick(4'b0001);
    vectors++;
    if (GNT !== 4'b0001) begin
      miscompares++;
      $display("FAIL async_setup: GNT=%b, required 0001", GNT);
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (EN !== 4'b0000 || ENB !== 4'b1111 || GNT !== 4'b0000 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: EN=%b ENB=%b GNT=%b BUSY=%b, required 0000/1111/0000/0", EN, ENB, GNT, BUSY);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(4'b0001);
      vectors++;
      if (GNT !== exp_gnt || BUSY !== exp_busy) begin
        miscompares++;
        $display("FAIL async_regrant[%0d]: GNT=%b BUSY=%b, required GNT=%b BUSY=%b", i, GNT, BUSY, exp_gnt, exp_busy);
      end
    end
    tick(4'b0000);
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b0000;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gf180mcu_as_ex_mcu7t5v0__trans_arb.md
GF180MCU_AS_EX_MCU7T5V0__TRANS_ARB -- requirements
Module: gf180mcu_as_ex_mcu7t5v0__trans_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one transmission-gate bus (2..8).
REQ-002 Parameter DEAD_CYCLES, default 2, break-before-make dead time in CLK cycles (>=1).
REQ-003 Parameter MAX_HOLD, default 16, maximum ON cycles before preemption when another request is pending; 0 disables preemption.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 REQ  input  NREQ  per-requester bus request, level-sensitive.
REQ-007 GNT  output  NREQ  per-requester grant, one-hot or zero.
REQ-008 EN  output  NREQ  transmission-gate enable per requester, drives trans cell EN.
REQ-009 ENB  output  NREQ  complementary enable per requester, drives trans cell ENB.
REQ-010 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, BBM (break-before-make) and ON.
REQ-012 GNT, EN and ENB SHALL be registered outputs; ENB SHALL equal the bitwise inverse of EN at all times; EN SHALL equal GNT.
REQ-013 At most one bit of EN SHALL be high in any cycle; EN SHALL be all-zero in IDLE and BBM.
REQ-014 Round-robin: a pointer PTR (reset 0) marks the highest-priority index; winner = first i with REQ[i]=1 scanning PTR, PTR+1, ... modulo NREQ.
REQ-015 IDLE: if any REQ bit is 1 at an edge, latch winner W, load the dead counter, go BBM; otherwise stay IDLE.
REQ-016 BBM SHALL last exactly DEAD_CYCLES cycles: REQ sampled at edge k -> GNT[W]/EN[W] high after edge k+DEAD_CYCLES.
REQ-017 If REQ[W] is 0 at any edge during BBM, the FSM SHALL return to IDLE without granting; PTR unchanged.
REQ-018 ON: GNT[W]=EN[W]=1, ENB[W]=0; a hold counter starts at 0 on entry and increments each ON cycle, saturating at MAX_HOLD.
REQ-019 ON release: REQ[W]=0 at an edge -> GNT/EN all-zero after that edge, state IDLE, PTR=(W+1) mod NREQ.
REQ-020 ON preemption: MAX_HOLD>0, hold counter = MAX_HOLD and any REQ[j]=1 with j!=W at an edge -> same action as REQ-019 regardless of REQ[W].
REQ-021 With no other request pending, the owner SHALL keep the grant indefinitely (no preemption).
REQ-022 Ownership handover SHALL therefore present 1 IDLE cycle plus DEAD_CYCLES BBM cycles of EN all-zero between owners.
REQ-023 Changes to REQ bits other than W during BBM or ON SHALL not affect the current transaction.
REQ-024 Dead and hold counters SHALL be sized to hold DEAD_CYCLES and MAX_HOLD without wrap.

Reset
REQ-025 RST=1 SHALL immediately, without a clock edge, force state IDLE, GNT=0, EN=0, ENB=all ones, BUSY=0, PTR=0, counters 0.
REQ-026 Reset asserted mid-BBM or mid-ON SHALL open all gates asynchronously; after RST deasserts, the first grant SHALL again take the full DEAD_CYCLES BBM.

Verification (NREQ=4, DEAD_CYCLES=2, MAX_HOLD=16)
REQ-027 Reset: RST=1 with REQ=1111 -> EN=0000, ENB=1111, GNT=0000, BUSY=0, held while RST=1.
REQ-028 Single: REQ=0100 first sampled at edge k -> BUSY=1 after k, GNT=EN=0100, ENB=1011 after edge k+2; REQ=0000 at edge m -> EN=0000, ENB=1111 after edge m.
REQ-029 Round-robin: REQ=1111, each owner dropping its bit one cycle after grant then re-raising it -> grant order 0,1,2,3,0 with >=3 zero-EN cycles between grants.
REQ-030 Preemption: REQ[0] held high and granted, REQ[2] raised -> GNT=0000 after 16th ON cycle, EN=0000 for 3 cycles, then GNT=0100.
REQ-031 Abort: REQ=0010 for a single cycle -> BBM entered, returns to IDLE, GNT never asserts, next grant still starts at index 0.
REQ-032 Async reset: RST pulsed between edges while GNT=0001 -> EN=0000, ENB=1111 before the next CLK edge; assertion checks ENB==~EN and EN one-hot-or-zero throughout all scenarios.
